// File: rtl/booth_mult_seq_if.sv
// booth_mult_seq_if: start/done handshake and operand/product bus for the Booth multiplier
interface booth_mult_seq_if #(parameter int WIDTH = 8);
    logic start;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic [2*WIDTH-1:0] product;
    logic busy;
    logic done;
    modport master (output start, multiplicand, multiplier, input product, busy, done);
    modport slave (input start, multiplicand, multiplier, output product, busy, done);
endinterface

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier, one step per clock, start/done handshake.
// Define BOOTH_MULT_UNSIGNED_EN for unsigned operands (one extra iteration).
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input logic clk,
    input logic rst,
    booth_mult_seq_if.slave bus
);
`ifdef BOOTH_MULT_UNSIGNED_EN
    localparam int QW = WIDTH + 1;
`else
    localparam int QW = WIDTH;
`endif
    localparam int CW = $clog2(QW + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH:0] a_q, a_d, m_q, m_d, sum, m_ext;
    logic [QW-1:0] q_q, q_d, q_load;
    logic qm1_q, qm1_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic busy_q, busy_d, done_q, done_d;
    logic [WIDTH+QW+1:0] shifted;
`ifdef BOOTH_MULT_UNSIGNED_EN
    assign m_ext = {1'b0, bus.multiplicand};
    assign q_load = {1'b0, bus.multiplier};
`else
    assign m_ext = {bus.multiplicand[WIDTH-1], bus.multiplicand};
    assign q_load = bus.multiplier;
`endif
    // Add/subtract and arithmetic shift of {A,Q,q_m1} folded into one expression
    always_comb begin
        sum = (q_q[0] & ~qm1_q) ? a_q - m_q : (~q_q[0] & qm1_q) ? a_q + m_q : a_q;
        shifted = {sum[WIDTH], sum, q_q};
        state_d = state_q;
        a_d = a_q;
        m_d = m_q;
        q_d = q_q;
        qm1_d = qm1_q;
        cnt_d = cnt_q;
        product_d = product_q;
        busy_d = busy_q;
        done_d = done_q;
        if (state_q == IDLE) begin
            if (bus.start) begin
                a_d = '0;
                q_d = q_load;
                qm1_d = 1'b0;
                m_d = m_ext;
                cnt_d = CW'(QW);
                busy_d = 1'b1;
                state_d = RUN;
            end
        end else if (state_q == RUN) begin
            a_d = shifted[WIDTH+QW+1:QW+1];
            q_d = shifted[QW:1];
            qm1_d = shifted[0];
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                product_d = shifted[2*WIDTH:1];
                done_d = 1'b1;
                state_d = DONE;
            end
        end else begin
            done_d = 1'b0;
            busy_d = 1'b0;
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q <= '0;
            m_q <= '0;
            q_q <= '0;
            qm1_q <= 1'b0;
            cnt_q <= '0;
            product_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            m_q <= m_d;
            q_q <= q_d;
            qm1_q <= qm1_d;
            cnt_q <= cnt_d;
            product_q <= product_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end
    assign bus.product = product_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: directed vectors with hand-computed products for booth_mult_seq
module tb_booth_mult_seq;
    localparam int W = 8;
`ifdef BOOTH_MULT_UNSIGNED_EN
    localparam int LAT = W + 1;
`else
    localparam int LAT = W;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    booth_mult_seq_if #(.WIDTH(W)) bus();
    booth_mult_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic mul(input string tag, input logic [7:0] m, input logic [7:0] q, input logic [15:0] exp);
        int n;
        bit seen;
        bus.start = 1'b1;
        bus.multiplicand = m;
        bus.multiplier = q;
        tick();
        bus.start = 1'b0;
        bus.multiplicand = ~m;
        bus.multiplier = ~q;
        chk({tag, "_busy"}, 32'(bus.busy), 1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            tick();
            n++;
            seen = bus.done;
        end
        chk({tag, "_lat"}, n, LAT);
        chk({tag, "_prod"}, 32'(bus.product), 32'(exp));
        tick();
        chk({tag, "_idle_busy"}, 32'(bus.busy), 0);
        chk({tag, "_idle_done"}, 32'(bus.done), 0);
    endtask
    initial begin
        bit seen;
        bus.start = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        tick();
        tick();
        chk("rst_prod", 32'(bus.product), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        rst = 1'b0;
        tick();
`ifdef BOOTH_MULT_UNSIGNED_EN
        mul("u255x255", 8'hFF, 8'hFF, 16'hFE01);
        mul("u128x2", 8'h80, 8'h02, 16'h0100);
        mul("u7x5", 8'h07, 8'h05, 16'h0023);
`else
        mul("m7q5", 8'h07, 8'h05, 16'h0023);
        mul("n128n128", 8'h80, 8'h80, 16'h4000);
        mul("n128p127", 8'h80, 8'h7F, 16'hC080);
        mul("n1n1", 8'hFF, 8'hFF, 16'h0001);
        mul("zero_m", 8'h00, 8'h5A, 16'h0000);
        mul("zero_q", 8'h5A, 8'h00, 16'h0000);
        bus.start = 1'b1;
        bus.multiplicand = 8'd3;
        bus.multiplier = 8'd4;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.start = 1'b1;
        bus.multiplicand = 8'd9;
        bus.multiplier = 8'd9;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        chk("ign_done", 32'(bus.done), 1);
        chk("ign_prod", 32'(bus.product), 32'h000C);
        bus.start = 1'b1;
        bus.multiplicand = 8'd5;
        bus.multiplier = 8'd5;
        tick();
        bus.start = 1'b0;
        chk("ign_pulse", 32'(bus.done), 0);
        tick();
        chk("ign_busy", 32'(bus.busy), 0);
        mul("after_ign", 8'd2, 8'd3, 16'h0006);
        bus.start = 1'b1;
        bus.multiplicand = 8'd3;
        bus.multiplier = 8'd3;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_prod", 32'(bus.product), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_done", 32'(bus.done), 0);
        tick();
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            seen = seen | bus.done;
        end
        chk("arst_nodone", 32'(seen), 0);
        mul("n3p9", 8'hFD, 8'h09, 16'hFFE5);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Sequential radix-2 Booth multiplier. It is the multiply counterpart to the team's sequential non-restoring divider.
- Takes two signed WIDTH-bit operands and produces a signed 2*WIDTH-bit product over WIDTH iterations, one iteration per clock.
- Sits in the arithmetic datapath beside the divider and uses the same start/done style handshake.
- The divider's 16-bit dividend width matches this block's product width at the default WIDTH=8.

Parameters:
- WIDTH, 8, operand width in bits. The product is 2*WIDTH bits. Valid range is 4..16.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- multiplicand  input  WIDTH  operand M, two's complement; captured on start acceptance.
- multiplier  input  WIDTH  operand Q, two's complement; captured on start acceptance.
- product  output  2*WIDTH  registered result, two's complement.
- busy  output  1  high while in RUN or DONE.
- done  output  1  one-cycle pulse; product is valid when done is high.

Behaviour:
- Reset (asynchronous, active-high, effective immediately):
  - State goes to IDLE; product, busy, done = 0.
  - Internal A, Q, q_m1, M and counter are cleared.
- Reset mid-operation aborts the multiply. No done is produced for the aborted operation.
- Internal registers:
  - A: WIDTH+1 bits, signed accumulator. The extra bit prevents overflow when M = -2^(WIDTH-1).
  - Q: WIDTH bits.
  - q_m1: 1 bit.
  - M: WIDTH+1 bits, sign-extended multiplicand.
  - cnt: ceil(log2(WIDTH+1)) bits.
- State IDLE:
  - busy=0, done=0.
  - If start=1 at a rising edge: A<=0, Q<=multiplier, q_m1<=0, M<=sext(multiplicand), cnt<=WIDTH, state<=RUN.
  - Operands are sampled only at this edge; later operand changes have no effect.
- State RUN (one Booth step per edge):
  - {Q[0],q_m1}=01: A<=A+M. =10: A<=A-M. =00 or 11: A unchanged.
  - Then arithmetic right shift of {A,Q,q_m1} by one, replicating A's MSB. Implement the add and the shift in one registered expression.
  - cnt<=cnt-1.
  - On the edge where cnt goes 1->0: product<={A'[WIDTH-1:0],Q'} (post-step values), done<=1, state<=DONE.
- State DONE: lasts exactly one cycle. done<=0, state<=IDLE; busy stays high through this cycle.
- Latency:
  - start accepted at edge E0; done and product visible after edge E_WIDTH (8 cycles at default).
  - Next start is accepted no earlier than edge E_(WIDTH+2).
  - Throughput is one result per WIDTH+2 cycles.
- start while busy (RUN or DONE) is ignored; there is no queuing.
- product holds its value until the next completed operation overwrites it; it is not cleared on start.
- Boundary cases:
  - Most-negative operand, e.g. -128*-128 = +16384, must be exact.
  - Zero operands produce 0.
  - No overflow flag is needed: the product always fits in 2*WIDTH bits.

Optional Feature:
- Macro: BOOTH_MULT_UNSIGNED_EN.
- When defined:
  - Operands are unsigned, zero-extended to WIDTH+1 bits, and Q widens to WIDTH+1.
  - cnt loads WIDTH+1; latency becomes WIDTH+1 cycles from E0 to done.
  - product = low 2*WIDTH bits of the {A,Q} result, i.e. the exact unsigned product.
- When undefined: signed behaviour as specified above.
- Port list is identical in both builds.

Test Plan:
- Reset, then start with M=7, Q=5 -> busy=1 from E0; done pulses after exactly 8 edges with product=0x0023; busy=0 one cycle later.
- M=-128 (0x80), Q=-128 -> product=0x4000. M=-128, Q=127 -> product=0xC080. M=-1, Q=-1 -> product=0x0001.
- M=0, Q=0x5A -> product=0x0000. Then M=0x5A, Q=0 -> product=0x0000. Back-to-back starts are accepted every 10 cycles.
- Start M=3, Q=4; assert start again and change operands at cycles 2 and 8 -> the second start is ignored and product=0x000C. Start issued in IDLE afterwards is accepted.
- Assert rst at cycle 4 of a multiply -> product, busy and done are 0 immediately (asynchronous) and no done pulse appears. After release, a new start M=-3, Q=9 gives 0xFFE5.
- With BOOTH_MULT_UNSIGNED_EN defined: M=255, Q=255 -> product=0xFE01 after 9 edges. M=128, Q=2 -> product=0x0100.
